// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit codes here feed the seven-segment mux directly.
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MINUS = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    DONE
  } state_t;

  // floor(width*log10(2)) + 1 digits hold any width-bit unsigned value
  function automatic int int_digits(input int width);
    return ((width * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/seq_bin_to_bcd_add3.sv
// Single BCD digit correction step for double dabble.
// Digits of 5 or more get 3 added so the next shift carries correctly.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle double-dabble converter with blanking and saturation.
// Define BCD_SIGNED_EN for two's-complement input with a minus digit.
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 neg,
  output logic [3:0]           bcd_out [0:DIGITS-1]
);

  localparam int ID = int_digits(BIN_WIDTH);
  localparam int AD = (DIGITS > ID) ? DIGITS : ID;
  localparam int CW = $clog2(BIN_WIDTH);

  state_t state, state_n;

  logic [BIN_WIDTH-1:0] sh;
  logic [BIN_WIDTH-1:0] load_val;
  logic [4*ID-1:0]      acc;
  logic [4*ID-1:0]      acc_fix;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 step;
  logic                 finish;
  logic [3:0]           dig [0:AD-1];
  logic [3:0]           res [0:DIGITS-1];
  logic                 ovf_n;
  logic                 neg_n;
  logic                 nz;
  int                   top;

`ifdef BCD_SIGNED_EN
  logic sgn;
  assign load_val = bin_in[BIN_WIDTH-1] ? -bin_in : bin_in;
`else
  assign load_val = bin_in;
`endif

  for (genvar g = 0; g < ID; g++) begin : g_fix
    bcd_add3 u_add3 (
      .d (acc[4*g +: 4]),
      .q (acc_fix[4*g +: 4])
    );
  end

  // Zero-extend the accumulator when more digits are shown than computed
  for (genvar g = 0; g < AD; g++) begin : g_dig
    if (g < ID) begin : g_acc
      assign dig[g] = acc[4*g +: 4];
    end else begin : g_pad
      assign dig[g] = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == '0) state_n = FINISH;
      end
      FINISH: begin
        finish  = 1'b1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Digit indices below are LSD-first; res[0] is the units digit
  always_comb begin
    ovf_n = 1'b0;
    neg_n = 1'b0;
    nz    = 1'b0;
    top   = 0;
    for (int p = DIGITS; p < AD; p++)
      if (dig[p] != 4'd0) ovf_n = 1'b1;
    for (int p = 0; p < DIGITS; p++)
      if (dig[p] != 4'd0) begin
        top = p;
        nz  = 1'b1;
      end
    for (int p = 0; p < DIGITS; p++)
      res[p] = (p > top) ? BCD_BLANK : dig[p];
`ifdef BCD_SIGNED_EN
    if (sgn && (nz || ovf_n)) begin
      neg_n = 1'b1;
      if (top < DIGITS - 1) begin
        for (int p = 0; p < DIGITS; p++)
          if (p == top + 1) res[p] = BCD_MINUS;
      end else begin
        ovf_n = 1'b1;
      end
    end
`endif
    if (ovf_n)
      for (int p = 0; p < DIGITS; p++) res[p] = 4'h9;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      neg      <= 1'b0;
`ifdef BCD_SIGNED_EN
      sgn      <= 1'b0;
`endif
      for (int i = 0; i < DIGITS; i++)
        bcd_out[i] <= (i == DIGITS - 1) ? 4'h0 : BCD_BLANK;
    end else begin
      busy <= (state_n == SHIFT) || (state_n == FINISH);
      done <= finish;
      if (accept) begin
        sh  <= load_val;
        acc <= '0;
        cnt <= CW'(BIN_WIDTH - 1);
`ifdef BCD_SIGNED_EN
        sgn <= bin_in[BIN_WIDTH-1];
`endif
      end else if (step) begin
        acc <= {acc_fix[4*ID-2:0], sh[BIN_WIDTH-1]};
        sh  <= sh << 1;
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        overflow <= ovf_n;
        neg      <= neg_n;
        for (int i = 0; i < DIGITS; i++)
          bcd_out[i] <= res[DIGITS-1-i];
      end
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed bench for seq_bin_to_bcd at BIN_WIDTH=16, DIGITS=4.
// Signed cases are selected by BCD_SIGNED_EN.
module tb_seq_bin_to_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        neg;
  logic [3:0]  bcd_out [0:3];

  int n_tests = 0;
  int n_fail  = 0;

  seq_bin_to_bcd #(.BIN_WIDTH(16), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .neg      (neg),
    .bcd_out  (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digs();
    return {bcd_out[0], bcd_out[1], bcd_out[2], bcd_out[3]};
  endfunction

  // Start cycle is cycle 0; each later edge advances one cycle.
  // Returns the cycle whose sample shows done, or -1 on timeout.
  task automatic wait_done(inout int cyc);
    while (cyc < 60) begin
      @(negedge clk);
      if (done) return;
      @(posedge clk);
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic convert(input logic [15:0] v, output int cyc);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    cyc = 1;
    #1;
    start  = 1'b0;
    bin_in = 16'hA5A5;
    wait_done(cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bin_in = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, overflow, neg} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, neg});
    end
    n_tests++;
    if (digs() !== 16'hFFF0) begin
      n_fail++;
      $display("FAIL reset_digits: got %h want fff0", digs());
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd0;
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: got %b want 1", busy);
    end
    @(posedge clk);
    cyc++;
    wait_done(cyc);
    n_tests++;
    if (cyc != 18) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d want 18", cyc);
    end
    n_tests++;
    if ({digs(), overflow, busy} !== {16'hFFF0, 2'b00}) begin
      n_fail++;
      $display("FAIL zero_result: got %h ovf %b busy %b want fff0 0 0",
               digs(), overflow, busy);
    end
    @(negedge clk);
    n_tests++;
    if ({done, digs()} !== {1'b0, 16'hFFF0}) begin
      n_fail++;
      $display("FAIL done_pulse_hold: got done %b %h want 0 fff0", done, digs());
    end
  endtask

  task automatic test_values();
    logic [15:0] vin  [5] = '{16'd305, 16'd9999, 16'd1234, 16'd12345, 16'd65535};
    logic [15:0] vexp [5] = '{16'hF305, 16'h9999, 16'h1234, 16'h9999, 16'h9999};
    logic        vovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      convert(vin[i], cyc);
      n_tests++;
      if (cyc != 18 || digs() !== vexp[i] || overflow !== vovf[i] || neg !== 1'b0) begin
        n_fail++;
        $display("FAIL value_%0d: got cyc %0d %h ovf %b neg %b want 18 %h ovf %b neg 0",
                 vin[i], cyc, digs(), overflow, neg, vexp[i], vovf[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd42;
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd7;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_mid: got %b want 1", busy);
    end
    @(posedge clk);
    cyc++;
    #1 start = 1'b0;
    wait_done(cyc);
    n_tests++;
    if (cyc != 18 || digs() !== 16'hFF42) begin
      n_fail++;
      $display("FAIL ignore_start: got cyc %0d %h want 18 ff42", cyc, digs());
    end
    start = 1'b1;
    bin_in = 16'd5678;
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    wait_done(cyc);
    n_tests++;
    if (cyc != 18 || digs() !== 16'h5678) begin
      n_fail++;
      $display("FAIL start_on_done: got cyc %0d %h want 18 5678", cyc, digs());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd9999;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || digs() !== 16'hFFF0) begin
      n_fail++;
      $display("FAIL reset_abort: got busy %b %h want 0 fff0", busy, digs());
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses want 0", seen);
    end
    convert(16'd5, cyc);
    n_tests++;
    if (cyc != 18 || digs() !== 16'hFFF5) begin
      n_fail++;
      $display("FAIL after_reset: got cyc %0d %h want 18 fff5", cyc, digs());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd1234;
    @(posedge clk);
    cyc = 1;
    #1 bin_in = 16'd305;
    wait_done(cyc);
    n_tests++;
    if (cyc != 18 || digs() !== 16'h1234) begin
      n_fail++;
      $display("FAIL b2b_first: got cyc %0d %h want 18 1234", cyc, digs());
    end
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    wait_done(cyc);
    n_tests++;
    if (cyc != 18 || digs() !== 16'hF305) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc %0d %h want 18 f305", cyc, digs());
    end
  endtask

  task automatic test_sign();
    int cyc;
`ifdef BCD_SIGNED_EN
    logic [15:0] vin  [4] = '{16'hFFD6, 16'hFB2E, 16'h8000, 16'h0000};
    logic [15:0] vexp [4] = '{16'hFE42, 16'h9999, 16'h9999, 16'hFFF0};
    logic        vovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        vneg [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    logic [15:0] vin  [4] = '{16'hFFD6, 16'h8000, 16'h270F, 16'h0000};
    logic [15:0] vexp [4] = '{16'h9999, 16'h9999, 16'h9999, 16'hFFF0};
    logic        vovf [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        vneg [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      convert(vin[i], cyc);
      n_tests++;
      if (cyc != 18 || digs() !== vexp[i] || overflow !== vovf[i] || neg !== vneg[i]) begin
        n_fail++;
        $display("FAIL sign_%h: got cyc %0d %h ovf %b neg %b want 18 %h ovf %b neg %b",
                 vin[i], cyc, digs(), overflow, neg, vexp[i], vovf[i], vneg[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_sign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_bin_to_bcd.md
# seq_bin_to_bcd

Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It replaces the fixed 16-bit/4-digit combinational converter in the LED display path. It adds a start/busy/done handshake, overflow saturation, and leading-zero blanking for any width and digit count. Output feeds the seven-segment digit mux directly; code 4'hF means "blank digit".

## Interface
- BIN_WIDTH, 16: width of the unsigned binary input, 4..32.
- DIGITS, 4: number of BCD digits presented, 1..10.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request conversion; sampled only when busy=0.
- bin_in  in  BIN_WIDTH  value to convert; captured on the accepted start edge only.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; bcd_out/overflow/neg valid and updated on this cycle.
- overflow  out  1  result does not fit in DIGITS positions.
- neg  out  1  result negative (signed build only, else constant 0).
- bcd_out  out  [3:0] x [0:DIGITS-1]  unpacked digit array; index 0 is most significant.

## Operation
- Internal digit count INT_DIGITS = ((BIN_WIDTH*1233)>>12)+1, enough for any BIN_WIDTH-bit value.
- FSM states:
  - IDLE: start=1 loads shift register and clears accumulator → SHIFT.
  - SHIFT: for BIN_WIDTH cycles, add 3 to every accumulator digit ≥5, then shift left one bit → FINISH.
  - FINISH: overflow, blanking and saturation → DONE.
  - DONE: done=1, outputs loaded → IDLE.
  - start in DONE is accepted exactly as in IDLE, giving back-to-back conversions.
- start while busy=1 is ignored; no queueing.
- Overflow: set when any accumulator digit at index ≥ DIGITS is nonzero. All DIGITS outputs then read 4'h9.
- Leading-zero suppression: every zero digit above the most significant nonzero digit reads 4'hF. The least significant digit is never blanked, so zero shows as blanks followed by 0.
- Outputs are registered and hold their value between done pulses.
- Reset values:
  - busy=0, done=0, overflow=0, neg=0.
  - bcd_out[0..DIGITS-2]=4'hF, bcd_out[DIGITS-1]=4'h0.
  - FSM returns to IDLE.
- Reset mid-conversion aborts the conversion with no done pulse; outputs return to reset values.

## Timing
- Accepted start on edge T.
- busy high T+1 .. T+BIN_WIDTH+1.
- done high in cycle T+BIN_WIDTH+2, with outputs updated on the same edge.
- Latency start→done = BIN_WIDTH+2 cycles (18 for the defaults).
- Throughput: one conversion per BIN_WIDTH+2 cycles with start held or re-asserted on done.
- bin_in may change freely after the accepting edge.

## Configuration
- BCD_SIGNED_EN defined:
  - bin_in is two's complement. The magnitude (−2^(BIN_WIDTH−1) included) is converted; neg=1 for negative inputs.
  - Minus code 4'hE is placed in the digit immediately above the most significant nonzero digit.
  - If no blank position remains, overflow=1, all digits read 4'h9 and neg=1.
  - Zero is never negative.
- BCD_SIGNED_EN undefined: unsigned conversion, neg tied 0, code 4'hE never produced.

## Structure
- Shared package bcd_pkg holds:
  - BCD_BLANK=4'hF and BCD_MINUS=4'hE.
  - FSM state enum: IDLE, SHIFT, FINISH, DONE.
  - Function int_digits(width).
- One sub-module: bcd_add3, a combinational single-digit "≥5 add 3" corrector instantiated INT_DIGITS times in a generate loop.

## Test plan
Defaults BIN_WIDTH=16, DIGITS=4; outputs written as digits 0..3.
- start with 0 → done exactly 18 cycles after the accept edge; output `_ _ _ 0`; overflow=0.
- 305 → `_ 3 0 5`; 9999 → `9 9 9 9`; 1234 → `1 2 3 4`; overflow=0 for all three.
- 12345 and 65535 → overflow=1, output `9 9 9 9`.
- Start 42, then pulse start with 7 at cycle 5 (busy) → ignored, result `_ _ 4 2`. Then start 5678 on the done cycle → accepted, done 18 cycles later, result `5 6 7 8`.
- Assert rst during SHIFT cycle 8 → busy=0 and outputs read `_ _ _ 0` immediately; no done pulse; a fresh start of 5 then gives `_ _ _ 5`.
- With BCD_SIGNED_EN:
  - 16'hFFD6 (−42) → `_ E 4 2`, neg=1.
  - −1234 → overflow=1, `9 9 9 9`, neg=1.
  - 16'h8000 → overflow=1, neg=1.
  - 0 → `_ _ _ 0`, neg=0.
